tile_paint_datapath: RTL and testbench

//  Datapath paired with the graphics FSM for the Simon-style tile game.

---
 rtl/tile_paint_datapath_pkg.sv | 29 ++
 rtl/tile_paint_datapath_lfsr16.sv | 34 +++
 rtl/tile_paint_datapath.sv | 135 +++++++++++++
 tb/tb_tile_paint_datapath.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_paint_datapath_pkg.sv
// rtl/tile_paint_datapath_pkg.sv - shared constants and colour lookup for the tile paint datapath
package tile_paint_datapath_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  localparam int TILE_W_DEFAULT   = 40;
  localparam int TILE_H_DEFAULT   = 40;
  localparam int ORIGIN_X_DEFAULT = 40;
  localparam int ORIGIN_Y_DEFAULT = 20;

  localparam logic [2:0] COLOUR_RED    = 3'b100;
  localparam logic [2:0] COLOUR_GREEN  = 3'b010;
  localparam logic [2:0] COLOUR_BLUE   = 3'b001;
  localparam logic [2:0] COLOUR_YELLOW = 3'b110;
  localparam logic [2:0] FLASH_COLOUR  = 3'b111;

  function automatic logic [2:0] base_colour(input logic [1:0] idx);
    logic [2:0] c;
    case (idx)
      2'd0:    c = COLOUR_RED;
      2'd1:    c = COLOUR_GREEN;
      2'd2:    c = COLOUR_BLUE;
      default: c = COLOUR_YELLOW;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tile_paint_datapath_lfsr16.sv
// rtl/tile_paint_datapath_lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) with lock-up recovery
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // The all-zero state would lock up, so it is reloaded regardless of en.
  always_comb begin
    q_d = q_q;
    if (q_q == 16'd0) begin
      q_d = SEED;
    end else if (en) begin
      q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tile_paint_datapath.sv
// rtl/tile_paint_datapath.sv - tile index/colour, paint counter and registered VGA pixel output
module tile_paint_datapath
  import tile_paint_datapath_pkg::*;
#(
  parameter int          TILE_W    = TILE_W_DEFAULT,
  parameter int          TILE_H    = TILE_H_DEFAULT,
  parameter int          ORIGIN_X  = ORIGIN_X_DEFAULT,
  parameter int          ORIGIN_Y  = ORIGIN_Y_DEFAULT,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ld_tile,
  input  logic           rand_sel,
  input  logic           keep_tile,
  input  logic [1:0]     tile_num,
  input  logic           ld_flash,
  input  logic           random_en,
  input  logic           counter_en,
  input  logic           write_en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           tile_done,
  output logic [1:0]     cur_tile
);

  localparam int CX_W = $clog2(TILE_W);
  localparam int CY_W = $clog2(TILE_H);
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(TILE_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(TILE_H - 1);

  logic [15:0]     lfsr;
  logic [1:0]      cur_tile_q, cur_tile_d;
  logic [2:0]      colour_reg_q, colour_reg_d;
  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            tile_done_q, tile_done_d;
  logic [X_W-1:0]  pix_x;
  logic [Y_W-1:0]  pix_y;
  logic            at_last;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .en    (random_en),
    .q     (lfsr)
  );

  assign at_last = (cx_q == CX_LAST) && (cy_q == CY_LAST);

  // Column comes from idx[0], row from idx[1].
  assign pix_x = X_W'(ORIGIN_X) + (cur_tile_q[0] ? X_W'(TILE_W) : X_W'(0)) + X_W'(cx_q);
  assign pix_y = Y_W'(ORIGIN_Y) + (cur_tile_q[1] ? Y_W'(TILE_H) : Y_W'(0)) + Y_W'(cy_q);

  always_comb begin
    cur_tile_d   = cur_tile_q;
    colour_reg_d = colour_reg_q;
    cx_d         = cx_q;
    cy_d         = cy_q;

    if (ld_tile) begin
      if (rand_sel) begin
        cur_tile_d = lfsr[1:0];
      end else if (!keep_tile) begin
        cur_tile_d = tile_num;
      end
      colour_reg_d = base_colour(cur_tile_d);
      cx_d         = '0;
      cy_d         = '0;
    end else if (counter_en) begin
      if (cx_q == CX_LAST) begin
        cx_d = '0;
        cy_d = (cy_q == CY_LAST) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end

    if (ld_flash) begin
      colour_reg_d = FLASH_COLOUR;
    end
  end

  // Output stage presents the pixel addressed by the counter before it advances.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = write_en;
    tile_done_d = write_en && counter_en && !ld_tile && at_last;
    if (write_en) begin
      x_d      = pix_x;
      y_d      = pix_y;
      colour_d = colour_reg_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_tile_q   <= '0;
      colour_reg_q <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      tile_done_q  <= 1'b0;
    end else begin
      cur_tile_q   <= cur_tile_d;
      colour_reg_q <= colour_reg_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      tile_done_q  <= tile_done_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign tile_done = tile_done_q;
  assign cur_tile  = cur_tile_q;

endmodule

// File: tb/tb_tile_paint_datapath.sv
// tb/tb_tile_paint_datapath.sv - directed self-checking bench for tile_paint_datapath
module tb_tile_paint_datapath;

  logic       clock = 1'b0;
  logic       reset;
  logic       ld_tile, rand_sel, keep_tile, ld_flash, random_en, counter_en, write_en;
  logic [1:0] tile_num;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, tile_done;
  logic [1:0] cur_tile;

  int n_checks = 0;
  int n_fail   = 0;

  tile_paint_datapath dut (
    .clock      (clock),
    .reset      (reset),
    .ld_tile    (ld_tile),
    .rand_sel   (rand_sel),
    .keep_tile  (keep_tile),
    .tile_num   (tile_num),
    .ld_flash   (ld_flash),
    .random_en  (random_en),
    .counter_en (counter_en),
    .write_en   (write_en),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .tile_done  (tile_done),
    .cur_tile   (cur_tile)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ld_tile = 0; rand_sel = 0; keep_tile = 0; tile_num = 2'd0;
    ld_flash = 0; random_en = 0; counter_en = 0; write_en = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic load_tile(input logic [1:0] idx);
    ld_tile = 1; tile_num = idx;
    tick();
    ld_tile = 0;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Paints n pixels with write_en+counter_en; checks coordinates against the tile origin.
  task automatic paint(input string tag, input int ox, input int oy, input int n,
                       input logic [2:0] exp_col, output int n_done, output int bad);
    n_done = 0;
    bad    = 0;
    write_en = 1; counter_en = 1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (x !== 8'(ox + i % 40) || y !== 7'(oy + i / 40) || plot !== 1'b1 || colour !== exp_col)
        bad++;
      if (tile_done) begin
        n_done++;
        if (i != 1599) bad++;
      end
      if (i == 0) begin
        check_eq({tag, "_first_x"}, 32'(x), 32'(ox));
        check_eq({tag, "_first_y"}, 32'(y), 32'(oy));
        check_eq({tag, "_first_colour"}, 32'(colour), 32'(exp_col));
      end
      if (i == 1599) begin
        check_eq({tag, "_last_x"}, 32'(x), 32'(ox + 39));
        check_eq({tag, "_last_y"}, 32'(y), 32'(oy + 39));
        check_eq({tag, "_last_done"}, 32'(tile_done), 32'd1);
      end
    end
    write_en = 0; counter_en = 0;
  endtask

  int         n_done, bad;
  logic [15:0] model;

  initial begin
    reset = 1;
    idle_inputs();

    // 1: reset state
    do_reset();
    check_eq("rst_x", 32'(x), 32'd0);
    check_eq("rst_y", 32'(y), 32'd0);
    check_eq("rst_colour", 32'(colour), 32'd0);
    check_eq("rst_plot", 32'(plot), 32'd0);
    check_eq("rst_done", 32'(tile_done), 32'd0);
    check_eq("rst_cur_tile", 32'(cur_tile), 32'd0);
    check_eq("rst_lfsr", 32'(dut.u_lfsr.q_q), 32'hACE1);

    // 2: full yellow tile 3
    load_tile(2'd3);
    check_eq("t2_cur_tile", 32'(cur_tile), 32'd3);
    paint("t2", 80, 60, 1600, 3'b110, n_done, bad);
    check_eq("t2_pixels_bad", 32'(bad), 32'd0);
    check_eq("t2_done_count", 32'(n_done), 32'd1);
    tick();
    check_eq("t2_idle_plot", 32'(plot), 32'd0);
    check_eq("t2_idle_done", 32'(tile_done), 32'd0);
    check_eq("t2_hold_x", 32'(x), 32'd119);
    check_eq("t2_hold_y", 32'(y), 32'd99);

    // 3: flash over tile 1, then reload same index without flash
    do_reset();
    load_tile(2'd1);
    ld_flash = 1;
    tick();
    ld_flash = 0;
    check_eq("t3_cur_tile", 32'(cur_tile), 32'd1);
    paint("t3", 80, 20, 1600, 3'b111, n_done, bad);
    check_eq("t3_pixels_bad", 32'(bad), 32'd0);
    ld_tile = 1; keep_tile = 1; tile_num = 2'd0;
    tick();
    ld_tile = 0; keep_tile = 0;
    write_en = 1;
    tick();
    write_en = 0;
    check_eq("t3_keep_tile", 32'(cur_tile), 32'd1);
    check_eq("t3_keep_colour", 32'(colour), 32'b010);
    check_eq("t3_keep_x", 32'(x), 32'd80);
    check_eq("t3_keep_y", 32'(y), 32'd20);

    // 3b: flash coinciding with ld_tile updates index, colour stays white
    ld_tile = 1; ld_flash = 1; tile_num = 2'd2;
    tick();
    ld_tile = 0; ld_flash = 0;
    write_en = 1;
    tick();
    write_en = 0;
    check_eq("t3b_tile", 32'(cur_tile), 32'd2);
    check_eq("t3b_colour", 32'(colour), 32'b111);

    // 4: random selection after one LFSR step
    do_reset();
    model = lfsr_step(16'hACE1);
    random_en = 1;
    tick();
    random_en = 0;
    check_eq("t4_lfsr", 32'(dut.u_lfsr.q_q), 32'(model));
    ld_tile = 1; rand_sel = 1;
    tick();
    ld_tile = 0; rand_sel = 0;
    check_eq("t4_cur_tile", 32'(cur_tile), 32'(model[1:0]));

    // 4b: rand_sel with random_en samples the pre-shift value
    ld_tile = 1; rand_sel = 1; random_en = 1;
    tick();
    ld_tile = 0; rand_sel = 0; random_en = 0;
    check_eq("t4b_cur_tile", 32'(cur_tile), 32'(model[1:0]));
    model = lfsr_step(model);
    check_eq("t4b_lfsr", 32'(dut.u_lfsr.q_q), 32'(model));

    // 5: silent advance to (5,3), re-issue, then ld_tile overrides counter_en
    do_reset();
    load_tile(2'd0);
    counter_en = 1;
    bad = 0;
    for (int i = 0; i < 125; i++) begin
      tick();
      if (plot !== 1'b0) bad++;
    end
    counter_en = 0;
    check_eq("t5_silent_plot", 32'(bad), 32'd0);
    write_en = 1;
    tick();
    check_eq("t5_mid_x", 32'(x), 32'd45);
    check_eq("t5_mid_y", 32'(y), 32'd23);
    tick();
    write_en = 0;
    check_eq("t5_reissue_x", 32'(x), 32'd45);
    check_eq("t5_reissue_plot", 32'(plot), 32'd1);
    ld_tile = 1; counter_en = 1; tile_num = 2'd2;
    tick();
    ld_tile = 0; counter_en = 0;
    write_en = 1;
    tick();
    write_en = 0;
    check_eq("t5_origin_x", 32'(x), 32'd40);
    check_eq("t5_origin_y", 32'(y), 32'd60);
    check_eq("t5_colour", 32'(colour), 32'b001);

    // 6: reset mid-tile
    do_reset();
    load_tile(2'd3);
    write_en = 1; counter_en = 1;
    for (int i = 0; i < 700; i++) tick();
    check_eq("t6_pre_plot", 32'(plot), 32'd1);
    reset = 1;
    tick();
    check_eq("t6_plot", 32'(plot), 32'd0);
    check_eq("t6_colour", 32'(colour), 32'd0);
    check_eq("t6_cx", 32'(dut.cx_q), 32'd0);
    check_eq("t6_cy", 32'(dut.cy_q), 32'd0);
    check_eq("t6_tile", 32'(cur_tile), 32'd0);
    reset = 0; counter_en = 0;
    tick();
    write_en = 0;
    check_eq("t6_after_x", 32'(x), 32'd40);
    check_eq("t6_after_y", 32'(y), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
